// File: rtl/ws2812_pkg.sv
// Shared WS2812 line timing, sizes and receiver state encoding.
// The display transmitter imports the same constants so both ends agree.
package ws2812_pkg;

    // Nominal transmit timing in 50 MHz clocks
    localparam int T0H            = 20;
    localparam int T1H            = 40;
    localparam int TBIT           = 62;

    // Receive decode thresholds in 50 MHz clocks
    localparam int T_BIT_THRESH   = 30;
    localparam int T_HIGH_MIN     = 10;
    localparam int T_HIGH_MAX     = 55;
    localparam int T_RESET        = 2500;

    localparam int BITS_PER_PIXEL = 24;
    localparam int NUM_PIXELS     = 192;

    localparam int CNT_W          = 12;
    localparam int PIX_W          = 8;

    typedef enum logic [1:0] {
        WAIT_GAP = 2'd0,
        IDLE     = 2'd1,
        HIGH     = 2'd2,
        LOW      = 2'd3
    } rx_state_t;

endpackage

// File: rtl/sync2.sv
// Multi-flop synchronizer for an asynchronous single-bit input (2 stages by default).
module sync2 #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic srst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] stage_reg;

    genvar gi;
    generate
        for (gi = 0; gi < STAGES; gi++) begin : g_stage
            if (gi == 0) begin : g_first
                always_ff @(posedge clk) begin
                    if (srst) stage_reg[0] <= 1'b0;
                    else      stage_reg[0] <= d;
                end
            end else begin : g_chain
                always_ff @(posedge clk) begin
                    if (srst) stage_reg[gi] <= 1'b0;
                    else      stage_reg[gi] <= stage_reg[gi-1];
                end
            end
        end
    endgenerate

    assign q = stage_reg[STAGES-1];

endmodule

// File: rtl/ws2812_rx.sv
// WS2812 single-wire receiver: decodes high-pulse widths into GRB pixel words,
// numbers them within the frame and reports the frame end on the long low gap.
module ws2812_rx
    import ws2812_pkg::*;
#(
    parameter int T_BIT_THRESH   = ws2812_pkg::T_BIT_THRESH,
    parameter int T_HIGH_MIN     = ws2812_pkg::T_HIGH_MIN,
    parameter int T_HIGH_MAX     = ws2812_pkg::T_HIGH_MAX,
    parameter int T_RESET        = ws2812_pkg::T_RESET,
    parameter int BITS_PER_PIXEL = ws2812_pkg::BITS_PER_PIXEL,
    parameter int NUM_PIXELS     = ws2812_pkg::NUM_PIXELS
) (
    input  logic                      CLOCK_50,
    input  logic                      reset,
    input  logic                      din,
    output logic                      pix_valid,
    output logic [BITS_PER_PIXEL-1:0] pix_data,
    output logic [PIX_W-1:0]          pix_index,
    output logic                      frame_done,
    output logic [PIX_W-1:0]          frame_pixels,
    output logic                      err
);

    localparam int BIT_W = $clog2(BITS_PER_PIXEL);

    localparam logic [CNT_W-1:0] RESET_W  = CNT_W'(T_RESET);
    localparam logic [CNT_W-1:0] THRESH_W = CNT_W'(T_BIT_THRESH);
    localparam logic [CNT_W-1:0] MIN_W    = CNT_W'(T_HIGH_MIN);
    localparam logic [CNT_W-1:0] MAX_W    = CNT_W'(T_HIGH_MAX);
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(BITS_PER_PIXEL - 1);
    localparam logic [PIX_W-1:0] NUM_PIX  = PIX_W'(NUM_PIXELS);

    logic ds;
    logic ds_prev_reg;
    logic ds_rise;
    logic ds_fall;
    logic ds_edge;

    rx_state_t                 state_reg,        state_next;
    logic [CNT_W-1:0]          cnt_reg,          cnt_next;
    logic [BIT_W-1:0]          bit_cnt_reg,      bit_cnt_next;
    logic [BITS_PER_PIXEL-1:0] shift_reg,        shift_next;
    logic [PIX_W-1:0]          pix_cnt_reg,      pix_cnt_next;
    logic                      ovf_reg,          ovf_next;
    logic                      pix_valid_reg,    pix_valid_next;
    logic [BITS_PER_PIXEL-1:0] pix_data_reg,     pix_data_next;
    logic [PIX_W-1:0]          pix_index_reg,    pix_index_next;
    logic                      frame_done_reg,   frame_done_next;
    logic [PIX_W-1:0]          frame_pixels_reg, frame_pixels_next;
    logic                      err_reg,          err_next;

    logic [CNT_W-1:0]          width;
    logic                      gap_hit;
    logic                      bit_val;
    logic [BITS_PER_PIXEL-1:0] shifted;

    sync2 #(
        .STAGES(2)
    ) u_sync (
        .clk  (CLOCK_50),
        .srst (reset),
        .d    (din),
        .q    (ds)
    );

    assign ds_rise = ds & ~ds_prev_reg;
    assign ds_fall = ~ds & ds_prev_reg;
    assign ds_edge = ds_rise | ds_fall;

    // cnt_reg counts cycles since the last edge minus one, so the width of the
    // level that just ended (or has lasted so far) is cnt_reg + 1.
    assign width   = cnt_reg + CNT_W'(1);
    assign gap_hit = ~ds & ~ds_edge & (cnt_reg == RESET_W - CNT_W'(1));
    assign bit_val = (width >= THRESH_W);
    assign shifted = BITS_PER_PIXEL'({shift_reg, bit_val});

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            ds_prev_reg      <= 1'b0;
            state_reg        <= WAIT_GAP;
            cnt_reg          <= '0;
            bit_cnt_reg      <= '0;
            shift_reg        <= '0;
            pix_cnt_reg      <= '0;
            ovf_reg          <= 1'b0;
            pix_valid_reg    <= 1'b0;
            pix_data_reg     <= '0;
            pix_index_reg    <= '0;
            frame_done_reg   <= 1'b0;
            frame_pixels_reg <= '0;
            err_reg          <= 1'b0;
        end else begin
            ds_prev_reg      <= ds;
            state_reg        <= state_next;
            cnt_reg          <= cnt_next;
            bit_cnt_reg      <= bit_cnt_next;
            shift_reg        <= shift_next;
            pix_cnt_reg      <= pix_cnt_next;
            ovf_reg          <= ovf_next;
            pix_valid_reg    <= pix_valid_next;
            pix_data_reg     <= pix_data_next;
            pix_index_reg    <= pix_index_next;
            frame_done_reg   <= frame_done_next;
            frame_pixels_reg <= frame_pixels_next;
            err_reg          <= err_next;
        end
    end

    always_comb begin
        state_next        = state_reg;
        bit_cnt_next      = bit_cnt_reg;
        shift_next        = shift_reg;
        pix_cnt_next      = pix_cnt_reg;
        ovf_next          = ovf_reg;
        pix_valid_next    = 1'b0;
        pix_data_next     = pix_data_reg;
        pix_index_next    = pix_index_reg;
        frame_done_next   = 1'b0;
        frame_pixels_next = frame_pixels_reg;
        err_next          = 1'b0;

        if (ds_edge)                cnt_next = '0;
        else if (cnt_reg != RESET_W) cnt_next = cnt_reg + CNT_W'(1);
        else                        cnt_next = cnt_reg;

        case (state_reg)
            WAIT_GAP: begin
                // Resynchronise silently: no frame_done for the gap that ends a bad frame.
                if (gap_hit) begin
                    bit_cnt_next = '0;
                    pix_cnt_next = '0;
                    ovf_next     = 1'b0;
                    state_next   = IDLE;
                end
            end

            IDLE: begin
                if (ds_rise) state_next = HIGH;
            end

            HIGH: begin
                if (ds_fall) begin
                    if (width < MIN_W) begin
                        err_next     = 1'b1;
                        bit_cnt_next = '0;
                        pix_cnt_next = '0;
                        ovf_next     = 1'b0;
                        state_next   = WAIT_GAP;
                    end else begin
                        shift_next = shifted;
                        state_next = LOW;
                        if (bit_cnt_reg == LAST_BIT) begin
                            bit_cnt_next = '0;
                            if (pix_cnt_reg < NUM_PIX) begin
                                pix_valid_next = 1'b1;
                                pix_data_next  = shifted;
                                pix_index_next = pix_cnt_reg;
                                pix_cnt_next   = pix_cnt_reg + PIX_W'(1);
                            end else if (!ovf_reg) begin
                                // Only the first surplus pixel of a frame is flagged.
                                err_next = 1'b1;
                                ovf_next = 1'b1;
                            end
                        end else begin
                            bit_cnt_next = bit_cnt_reg + BIT_W'(1);
                        end
                    end
                end else if (width >= MAX_W) begin
                    // Still high after T_HIGH_MAX cycles: the pulse is already too long.
                    err_next     = 1'b1;
                    bit_cnt_next = '0;
                    pix_cnt_next = '0;
                    ovf_next     = 1'b0;
                    state_next   = WAIT_GAP;
                end
            end

            LOW: begin
                if (ds_rise) begin
                    state_next = HIGH;
                end else if (gap_hit) begin
                    frame_done_next   = 1'b1;
                    frame_pixels_next = pix_cnt_reg;
                    err_next          = (bit_cnt_reg != '0);
                    bit_cnt_next      = '0;
                    pix_cnt_next      = '0;
                    ovf_next          = 1'b0;
                    state_next        = IDLE;
                end
            end

            default: state_next = WAIT_GAP;
        endcase
    end

    assign pix_valid    = pix_valid_reg;
    assign pix_data     = pix_data_reg;
    assign pix_index    = pix_index_reg;
    assign frame_done   = frame_done_reg;
    assign frame_pixels = frame_pixels_reg;
    assign err          = err_reg;

endmodule
